// File: rtl/spdif_pkg.sv
// Shared SPDIF types: sample widths, stereo packing and counter width.
// Imported by the transmitter core and by spdif_sample_fifo.
package spdif_pkg;

    localparam int SAMPLE_W       = 20;
    localparam int STEREO_W       = 40;
    localparam int LEFT_LSB       = 0;
    localparam int RIGHT_LSB      = 20;
    localparam int UNDERRUN_CNT_W = 16;

    // Right channel in the upper half, matching the producer bus packing.
    typedef struct packed {
        logic [SAMPLE_W-1:0] right;
        logic [SAMPLE_W-1:0] left;
    } stereo_sample_t;

endpackage

// File: rtl/spdif_fifo_ram.sv
// DEPTH x 40 simple dual-port array: synchronous write, combinational read.
// Contents are intentionally not reset.
module spdif_fifo_ram
    import spdif_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [STEREO_W-1:0] i_wr_data,
    input  logic [AW-1:0]       i_rd_addr,
    output logic [STEREO_W-1:0] o_rd_data
);

    logic [STEREO_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/spdif_sample_fifo.sv
// Stereo sample FIFO feeding the SPDIF transmitter with a prefetched output pair.
// Optional SPDIF_UNDERRUN_HOLD_EN: repeat the last pair on underrun instead of silence.
module spdif_sample_fifo
    import spdif_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      wr_valid_i,
    input  logic [STEREO_W-1:0]       wr_data_i,
    output logic                      wr_ready_o,
    input  logic                      sample_req_i,
    output logic [STEREO_W-1:0]       sample_o,
    output logic [AW:0]               level_o,
    output logic                      underrun_o,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count_o
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_level;
    stereo_sample_t            r_sample;
    logic                      r_underrun;
    logic [UNDERRUN_CNT_W-1:0] r_underrun_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_underrun;
    logic [STEREO_W-1:0] w_rd_data;

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign wr_ready_o = !w_full;
    // A flushed cycle drops the write even though ready was high.
    assign w_push     = wr_valid_i & !w_full & !flush_i;
    assign w_pop      = sample_req_i & !w_empty & !flush_i;
    assign w_underrun = sample_req_i & w_empty & !flush_i;

    spdif_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk_i),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_level          <= '0;
            r_sample         <= '0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else if (flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_sample   <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_underrun;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_sample <= w_rd_data;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_underrun) begin
`ifndef SPDIF_UNDERRUN_HOLD_EN
                r_sample <= '0;
`endif
                if (r_underrun_count != '1) begin
                    r_underrun_count <= r_underrun_count + 1'b1;
                end
            end
        end
    end

    assign sample_o         = r_sample;
    assign level_o          = r_level;
    assign underrun_o       = r_underrun;
    assign underrun_count_o = r_underrun_count;

endmodule

// File: tb/tb_spdif_sample_fifo.sv
// Self-checking bench for spdif_sample_fifo: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_spdif_sample_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic [39:0] wr_data;
    logic        wr_ready;
    logic        sample_req;
    logic [39:0] sample;
    logic [AW:0] level;
    logic        underrun;
    logic [15:0] underrun_count;

    int n_checks = 0;
    int n_fail   = 0;

    spdif_sample_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .wr_valid_i       (wr_valid),
        .wr_data_i        (wr_data),
        .wr_ready_o       (wr_ready),
        .sample_req_i     (sample_req),
        .sample_o         (sample),
        .level_o          (level),
        .underrun_o       (underrun),
        .underrun_count_o (underrun_count)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of stored pairs and the pair on the output.
    logic [39:0] exp_q[$];
    logic [39:0] exp_sample = '0;
    logic        exp_underrun = 1'b0;
    int          exp_count = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit room;
        if (rst) begin
            exp_q.delete();
            exp_sample   = '0;
            exp_underrun = 1'b0;
            exp_count    = 0;
        end else if (flush) begin
            exp_q.delete();
            exp_sample   = '0;
            exp_underrun = 1'b0;
        end else begin
            room         = (exp_q.size() < DEPTH);
            exp_underrun = 1'b0;
            if (sample_req) begin
                if (exp_q.size() > 0) begin
                    exp_sample = exp_q.pop_front();
                end else begin
                    exp_underrun = 1'b1;
                    if (exp_count < 65535) exp_count++;
`ifndef SPDIF_UNDERRUN_HOLD_EN
                    exp_sample = '0;
`endif
                end
            end
            // Push after the pop: a same-cycle write is never visible to the request.
            if (wr_valid && room) exp_q.push_back(wr_data);
        end
        #1;
        check("model_level", 40'(level), 40'(exp_q.size()));
        check("model_ready", 40'(wr_ready), 40'(exp_q.size() < DEPTH));
        check("model_sample", sample, exp_sample);
        check("model_underrun", 40'(underrun), 40'(exp_underrun));
        check("model_count", 40'(underrun_count), 40'(exp_count));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req_pulse();
        sample_req = 1'b1;
        cyc();
        sample_req = 1'b0;
    endtask

    task automatic write_one(input logic [39:0] d);
        int waited = 0;
        while (!wr_ready && waited < 50) begin
            cyc();
            waited++;
        end
        if (!wr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_timeout: ready stayed %b, required 1", wr_ready);
        end
        wr_valid = 1'b1;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; sample_req = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_level", 40'(level), 40'd0);
        check("rst_ready", 40'(wr_ready), 40'd1);
        check("rst_sample", sample, 40'h0);
        check("rst_count", 40'(underrun_count), 40'd0);

        // Underruns on an empty FIFO after reset.
        for (int i = 0; i < 3; i++) begin
            req_pulse();
            check("empty_underrun_pulse", 40'(underrun), 40'd1);
            cyc();
        end
        check("empty_count3", 40'(underrun_count), 40'd3);
        check("empty_sample0", sample, 40'h0);
        check("empty_level0", 40'(level), 40'd0);

        // Two writes then two requests.
        write_one(40'h0000100002);
        write_one(40'h0000300004);
        check("two_level2", 40'(level), 40'd2);
        req_pulse();
        check("pop1_sample", sample, 40'h0000100002);
        check("pop1_level", 40'(level), 40'd1);
        check("pop1_no_underrun", 40'(underrun), 40'd0);
        req_pulse();
        check("pop2_sample", sample, 40'h0000300004);
        check("pop2_level", 40'(level), 40'd0);
        check("pop2_count", 40'(underrun_count), 40'd3);

        // Fill to full with valid held high, then stall a 17th write.
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 40'(100 + i);
            cyc();
        end
        wr_data = 40'd200;
        cyc(); cyc();
        check("full_level16", 40'(level), 40'd16);
        check("full_ready0", 40'(wr_ready), 40'd0);
        sample_req = 1'b1;
        cyc();
        sample_req = 1'b0;
        check("full_pop_level15", 40'(level), 40'd15);
        check("full_pop_sample", sample, 40'd100);
        cyc();
        wr_valid = 1'b0;
        check("refill_level16", 40'(level), 40'd16);

        // Drain to level 5, then stream write+request together across the wrap.
        for (int i = 0; i < 11; i++) req_pulse();
        check("drain_sample", sample, 40'd111);
        check("drain_level5", 40'(level), 40'd5);
        wr_valid = 1'b1; sample_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = 40'(300 + i);
            cyc();
            check("stream_level5", 40'(level), 40'd5);
        end
        wr_valid = 1'b0; sample_req = 1'b0;
        check("stream_sample", sample, 40'd314);

        // Flush with a same-cycle write and request at level 3.
        req_pulse(); req_pulse();
        check("preflush_level3", 40'(level), 40'd3);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 40'd999; sample_req = 1'b1;
        cyc();
        flush = 1'b0; wr_valid = 1'b0; sample_req = 1'b0;
        check("flush_level0", 40'(level), 40'd0);
        check("flush_sample0", sample, 40'h0);
        check("flush_count", 40'(underrun_count), 40'd3);
        req_pulse();
        check("postflush_underrun", 40'(underrun), 40'd1);
        check("postflush_sample", sample, 40'h0);
        check("postflush_count", 40'(underrun_count), 40'd4);

        // Underrun after a real pair: silence, or the repeated pair when held.
        write_one(40'h123456789A);
        req_pulse();
        check("hold_pop_sample", sample, 40'h123456789A);
        req_pulse();
        check("hold_underrun", 40'(underrun), 40'd1);
`ifdef SPDIF_UNDERRUN_HOLD_EN
        check("hold_sample", sample, 40'h123456789A);
`else
        check("hold_sample", sample, 40'h0);
`endif
        check("hold_count", 40'(underrun_count), 40'd5);

        // Drive the counter into saturation.
        sample_req = 1'b1;
        repeat (65540) cyc();
        sample_req = 1'b0;
        cyc();
        check("sat_count", 40'(underrun_count), 40'hFFFF);
        check("sat_level", 40'(level), 40'd0);

        // Only reset clears the counter.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("reset_clears_count", 40'(underrun_count), 40'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
